// File: rtl/clock_generator.sv
// Integer clock divider: counts inputClock rising edges and toggles a
// registered square wave every InputClockEdgesToCount edges, giving
// f_out = f_in / (2 * InputClockEdgesToCount). Single-cycle rise/fall
// strobes are produced in the inputClock domain alongside the new level.
module clock_generator #(
  parameter int BitsNeeded             = 8,
  parameter int InputClockEdgesToCount = 35
) (
  input  logic inputClock,
  input  logic reset,
  output logic outputClock,
  output logic risePulse,
  output logic fallPulse
);

  // Refuse to build a divider whose terminal count does not fit the counter.
  generate
    if ((InputClockEdgesToCount < 1) ||
        (longint'(InputClockEdgesToCount) - 1 >= (longint'(1) << BitsNeeded))) begin : g_bad_params
      $error("clock_generator: InputClockEdgesToCount=%0d illegal for BitsNeeded=%0d",
             InputClockEdgesToCount, BitsNeeded);
    end
  endgenerate

  // Terminal count, compared over the full counter width.
  localparam logic [BitsNeeded-1:0] LastCount = BitsNeeded'(InputClockEdgesToCount - 1);

  logic [BitsNeeded-1:0] count_q;
  logic [BitsNeeded-1:0] count_d;
  logic                  out_clk_q;
  logic                  out_clk_d;
  logic                  rise_q;
  logic                  rise_d;
  logic                  fall_q;
  logic                  fall_d;
  logic                  wrap;

  // Next-state: reload and toggle at the terminal count, otherwise count up.
  always_comb begin
    wrap      = (count_q == LastCount);
    count_d   = count_q + 1'b1;
    out_clk_d = out_clk_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    if (wrap) begin
      count_d   = '0;
      out_clk_d = ~out_clk_q;
      // Strobe direction follows the level being left behind.
      rise_d    = ~out_clk_q;
      fall_d    = out_clk_q;
    end
  end

  // State registers; synchronous reset overrides everything, so a reset in
  // the high phase drops the output without a fall strobe.
  always_ff @(posedge inputClock) begin
    if (reset) begin
      count_q   <= '0;
      out_clk_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      out_clk_q <= out_clk_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
    end
  end

  // Outputs come straight from flops so the derived clock is glitch-free.
  assign outputClock = out_clk_q;
  assign risePulse   = rise_q;
  assign fallPulse   = fall_q;

endmodule

// File: tb/tb_clock_generator.sv
// Bench for clock_generator: three instances (N=35/8b, N=1/1b, N=4/2b)
// share one clock. Expected levels are derived arithmetically from the
// number of edges since reset release and queued before each edge.
module tb_clock_generator;

  logic clk = 1'b0;
  logic rst35, rst1, rst4;
  logic oc35, rp35, fp35;
  logic oc1, rp1, fp1;
  logic oc4, rp4, fp4;

  always #10 clk = ~clk;

  clock_generator #(.BitsNeeded(8), .InputClockEdgesToCount(35)) dut35 (
    .inputClock(clk), .reset(rst35), .outputClock(oc35), .risePulse(rp35), .fallPulse(fp35));
  clock_generator #(.BitsNeeded(1), .InputClockEdgesToCount(1)) dut1 (
    .inputClock(clk), .reset(rst1), .outputClock(oc1), .risePulse(rp1), .fallPulse(fp1));
  clock_generator #(.BitsNeeded(2), .InputClockEdgesToCount(4)) dut4 (
    .inputClock(clk), .reset(rst4), .outputClock(oc4), .risePulse(rp4), .fallPulse(fp4));

  typedef struct {
    int oc;
    int rise;
    int fall;
    int cnt;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int passes = 0;
  int k35 = 0, k1 = 0, k4 = 0;
  int rises = 0;
  bit count_rises = 0;
  bit track_phase = 0;
  bit seen_change = 0;
  int cyc = 0;
  int last_change = 0;
  int prev_oc = 0;

  // Expected outputs after k edges since release with divide count n.
  function automatic exp_t model(input int k, input int n);
    exp_t e;
    int q, r;
    e.oc = 0; e.rise = 0; e.fall = 0; e.cnt = 0;
    if (k > 0) begin
      q = k / n;
      r = k % n;
      e.oc   = q % 2;
      e.rise = (r == 0 && (q % 2) == 1) ? 1 : 0;
      e.fall = (r == 0 && (q % 2) == 0) ? 1 : 0;
      e.cnt  = r;
    end
    return e;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic cmp(input string tag, input exp_t e, input int oc, input int rp,
                     input int fp, input int cnt);
    check({tag, ".outputClock"}, oc, e.oc);
    check({tag, ".risePulse"}, rp, e.rise);
    check({tag, ".fallPulse"}, fp, e.fall);
    check({tag, ".counter"}, cnt, e.cnt);
  endtask

  // One inputClock edge: drive resets, queue expectations, sample #1 after edge.
  task automatic step(input logic r35, input logic r1, input logic r4);
    exp_t e;
    rst35 = r35; rst1 = r1; rst4 = r4;
    k35 = r35 ? 0 : k35 + 1;
    k1  = r1  ? 0 : k1 + 1;
    k4  = r4  ? 0 : k4 + 1;
    sb.push_back(model(k35, 35));
    sb.push_back(model(k1, 1));
    sb.push_back(model(k4, 4));
    @(posedge clk);
    #1;
    cyc++;
    if (sb.size() != 3) begin
      check("scoreboard_depth", sb.size(), 3);
    end else begin
      e = sb.pop_front(); cmp("n35", e, int'(oc35), int'(rp35), int'(fp35), int'(dut35.count_q));
      e = sb.pop_front(); cmp("n1",  e, int'(oc1),  int'(rp1),  int'(fp1),  int'(dut1.count_q));
      e = sb.pop_front(); cmp("n4",  e, int'(oc4),  int'(rp4),  int'(fp4),  int'(dut4.count_q));
    end
    if (count_rises && rp35) rises++;
    if (track_phase && int'(oc35) != prev_oc) begin
      if (seen_change) check("n35.phase_len", cyc - last_change, 35);
      seen_change = 1;
      last_change = cyc;
    end
    prev_oc = int'(oc35);
  endtask

  initial begin
    rst35 = 1'b1; rst1 = 1'b1; rst4 = 1'b1;
    // Reset held for 5 cycles: everything low.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1);
    // Release: rise at 35, fall at 70, rise at 105; N=1 and N=4 run alongside.
    for (int i = 0; i < 110; i++) step(1'b0, 1'b0, 1'b0);
    // Advance N=35 to the high phase with counter=20 (k=125).
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b0);
    check("n35.pre_reset_level", int'(oc35), 1);
    check("n35.pre_reset_count", int'(dut35.count_q), 20);
    // Mid-period reset on N=35 only: drops to 0 with no fall strobe.
    step(1'b1, 1'b0, 1'b0);
    check("n35.reset_no_fall", int'(fp35), 0);
    // Release and reach the first rise at the 35th edge.
    for (int i = 0; i < 36; i++) step(1'b0, 1'b0, 1'b0);
    // Long run over a 10000-cycle window starting after the first rise.
    prev_oc = int'(oc35);
    count_rises = 1;
    track_phase = 1;
    for (int i = 0; i < 10000; i++) step(1'b0, 1'b0, 1'b0);
    count_rises = 0;
    track_phase = 0;
    check("n35.rise_count_10000", rises, 142);
    // Final reset on all instances.
    step(1'b1, 1'b1, 1'b1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
